// File: rtl/data_cache_ml.sv
// Multi-line direct-mapped write-back AP data cache between the AP controller and DDR.
// Serves word (row) and bit-slice (column) access with automatic dirty eviction, FLUSH and INVALIDATE.
module data_cache_ml #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned LINE_DEPTH     = 16,
   parameter int unsigned NUM_LINES      = 4,
   parameter int unsigned ADDR_WIDTH_MEM = 16,
   parameter int unsigned ADDR_WIDTH_CAM = 8,
   parameter int unsigned DDR_ADDR_WIDTH = 28,
   parameter int unsigned DDR_ADDR_SHIFT = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_rdy,
   input  logic [2:0]                cmd,
   input  logic [ADDR_WIDTH_MEM-1:0] cmd_addr,
   input  logic [ADDR_WIDTH_CAM-1:0] cmd_col,
   input  logic [DATA_WIDTH-1:0]     wdata_rbr,
   input  logic [LINE_DEPTH-1:0]     wdata_cbc,
   output logic                      resp_valid,
   output logic                      resp_err,
   output logic [DATA_WIDTH-1:0]     rdata_rbr,
   output logic [LINE_DEPTH-1:0]     rdata_cbc,
   output logic [15:0]               miss_cnt,
   output logic                      ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
   input  logic                      ddr_rd_valid,
   input  logic [DATA_WIDTH-1:0]     ddr_rd_data,
   input  logic                      ddr_rd_done,
   output logic                      ddr_wr_req,
   output logic [DDR_ADDR_WIDTH-1:0] ddr_wr_addr,
   input  logic                      ddr_wr_data_req,
   output logic [DATA_WIDTH-1:0]     ddr_wr_data,
   input  logic                      ddr_wr_done
);

   localparam int unsigned OFF_W  = $clog2(LINE_DEPTH);
   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned TAG_W  = ADDR_WIDTH_MEM - OFF_W - IDX_W;
   localparam int unsigned COL_W  = $clog2(DATA_WIDTH);
   localparam int unsigned BEAT_W = OFF_W + 1;

   localparam logic [2:0] CMD_NOP    = 3'd0;
   localparam logic [2:0] CMD_ROW_LD = 3'd1;
   localparam logic [2:0] CMD_ROW_ST = 3'd2;
   localparam logic [2:0] CMD_COL_LD = 3'd3;
   localparam logic [2:0] CMD_COL_ST = 3'd4;
   localparam logic [2:0] CMD_FLUSH  = 3'd5;
   localparam logic [2:0] CMD_INVAL  = 3'd6;
   localparam logic [2:0] CMD_RSVD   = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_RESPOND, S_EVICT, S_FILL, S_FLUSH_SCAN, S_INVAL_CLR
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                cmd_q;
   logic [ADDR_WIDTH_MEM-1:0] addr_q;
   logic [ADDR_WIDTH_CAM-1:0] col_q;
   logic [DATA_WIDTH-1:0]     wrbr_q;
   logic [LINE_DEPTH-1:0]     wcbc_q;
   logic [NUM_LINES-1:0]      valid_q, dirty_q;
   logic [TAG_W-1:0]          tag_q [NUM_LINES];
   logic [DATA_WIDTH-1:0]     mem_q [NUM_LINES][LINE_DEPTH];
   logic [IDX_W-1:0]          line_q, line_d;
   logic [BEAT_W-1:0]         rd_beat_q, rd_beat_d, wr_beat_q, wr_beat_d;
   logic [15:0]               miss_q;
   logic                      resp_valid_q, resp_err_q, err_d;
   logic [DATA_WIDTH-1:0]     rdata_rbr_q;
   logic [LINE_DEPTH-1:0]     rdata_cbc_q, col_slice_c;

   logic accept_c, fill_we_c, row_we_c, col_we_c, ld_row_c, ld_col_c;
   logic miss_inc_c, fill_done_c, set_dirty_c, clr_dirty_c, inval_c;

   // Address decode of the latched command
   logic [OFF_W-1:0] off_c;
   logic [IDX_W-1:0] idx_c;
   logic [TAG_W-1:0] tag_c;
   logic [COL_W-1:0] colsel_c;
   logic             hit_c, bad_c;

   assign off_c    = addr_q[OFF_W-1:0];
   assign idx_c    = addr_q[OFF_W +: IDX_W];
   assign tag_c    = addr_q[ADDR_WIDTH_MEM-1 -: TAG_W];
   assign colsel_c = col_q[COL_W-1:0];
   assign hit_c    = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
   assign bad_c    = (cmd_q == CMD_RSVD) ||
                     (((cmd_q == CMD_COL_LD) || (cmd_q == CMD_COL_ST)) &&
                      (col_q >= ADDR_WIDTH_CAM'(DATA_WIDTH)));

   always_comb begin
      for (int j = 0; j < LINE_DEPTH; j++) col_slice_c[j] = mem_q[idx_c][j][colsel_c];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      rd_beat_d   = '0;
      wr_beat_d   = '0;
      accept_c    = 1'b0;
      fill_we_c   = 1'b0;
      row_we_c    = 1'b0;
      col_we_c    = 1'b0;
      ld_row_c    = 1'b0;
      ld_col_c    = 1'b0;
      miss_inc_c  = 1'b0;
      fill_done_c = 1'b0;
      set_dirty_c = 1'b0;
      clr_dirty_c = 1'b0;
      inval_c     = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               accept_c = 1'b1;
               case (cmd)
                  CMD_NOP:   state_d = S_IDLE;
                  CMD_FLUSH: begin
                     state_d = S_FLUSH_SCAN;
                     line_d  = '0;
                  end
                  CMD_INVAL: state_d = S_INVAL_CLR;
                  default:   state_d = S_LOOKUP;
               endcase
            end
         end
         S_LOOKUP: begin
            line_d = idx_c;
            if (bad_c) begin
               state_d = S_RESPOND;
               err_d   = 1'b1;
            end else if (hit_c) begin
               state_d = S_RESPOND;
               case (cmd_q)
                  CMD_ROW_ST: begin row_we_c = 1'b1; set_dirty_c = 1'b1; end
                  CMD_COL_ST: begin col_we_c = 1'b1; set_dirty_c = 1'b1; end
                  CMD_ROW_LD: ld_row_c = 1'b1;
                  CMD_COL_LD: ld_col_c = 1'b1;
                  default:    ;
               endcase
            end else begin
               miss_inc_c = 1'b1;
               state_d    = (valid_q[idx_c] && dirty_q[idx_c]) ? S_EVICT : S_FILL;
            end
         end
         S_EVICT: begin
            wr_beat_d = wr_beat_q;
            if (ddr_wr_data_req && (wr_beat_q < BEAT_W'(LINE_DEPTH)))
               wr_beat_d = wr_beat_q + BEAT_W'(1);
            if (ddr_wr_done) begin
               clr_dirty_c = 1'b1;
               state_d     = (cmd_q == CMD_FLUSH) ? S_FLUSH_SCAN : S_FILL;
            end
         end
         S_FILL: begin
            rd_beat_d = rd_beat_q;
            if (ddr_rd_valid && (rd_beat_q < BEAT_W'(LINE_DEPTH))) begin
               fill_we_c = 1'b1;
               rd_beat_d = rd_beat_q + BEAT_W'(1);
            end
            if (ddr_rd_done) begin
               fill_done_c = 1'b1;
               state_d     = S_LOOKUP;
            end
         end
         // A just-evicted line comes back here clean and is then passed over
         S_FLUSH_SCAN: begin
            if (dirty_q[line_q])                       state_d = S_EVICT;
            else if (line_q == IDX_W'(NUM_LINES - 1))  state_d = S_RESPOND;
            else                                       line_d  = line_q + IDX_W'(1);
         end
         S_INVAL_CLR: begin
            inval_c = 1'b1;
            state_d = S_RESPOND;
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_q        <= '0;
         addr_q       <= '0;
         col_q        <= '0;
         wrbr_q       <= '0;
         wcbc_q       <= '0;
         line_q       <= '0;
         rd_beat_q    <= '0;
         wr_beat_q    <= '0;
         miss_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_rbr_q  <= '0;
         rdata_cbc_q  <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
      end else begin
         if (accept_c) begin
            cmd_q  <= cmd;
            addr_q <= cmd_addr;
            col_q  <= cmd_col;
            wrbr_q <= wdata_rbr;
            wcbc_q <= wdata_cbc;
         end
         line_q       <= line_d;
         rd_beat_q    <= rd_beat_d;
         wr_beat_q    <= wr_beat_d;
         resp_valid_q <= (state_d == S_RESPOND);
         resp_err_q   <= err_d;
         if (miss_inc_c && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
         if (ld_row_c) rdata_rbr_q <= mem_q[idx_c][off_c];
         if (ld_col_c) rdata_cbc_q <= col_slice_c;
         if (inval_c) begin
            valid_q <= '0;
            dirty_q <= '0;
         end
         if (fill_done_c) begin
            valid_q[idx_c] <= 1'b1;
            dirty_q[idx_c] <= 1'b0;
            tag_q[idx_c]   <= tag_c;
         end
         if (set_dirty_c) dirty_q[idx_c]  <= 1'b1;
         if (clr_dirty_c) dirty_q[line_q] <= 1'b0;
      end
   end

   // Line storage carries no reset; valid bits gate its use
   always_ff @(posedge clk) begin
      if (fill_we_c) mem_q[idx_c][rd_beat_q[OFF_W-1:0]] <= ddr_rd_data;
      if (row_we_c)  mem_q[idx_c][off_c] <= wrbr_q;
      if (col_we_c) begin
         for (int j = 0; j < LINE_DEPTH; j++) mem_q[idx_c][j][colsel_c] <= wcbc_q[j];
      end
   end

   assign cmd_rdy     = (state_q == S_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign rdata_rbr   = rdata_rbr_q;
   assign rdata_cbc   = rdata_cbc_q;
   assign miss_cnt    = miss_q;
   assign ddr_rd_req  = (state_q == S_FILL);
   assign ddr_wr_req  = (state_q == S_EVICT);
   assign ddr_rd_addr = (state_q == S_FILL) ?
      (DDR_ADDR_WIDTH'({addr_q[ADDR_WIDTH_MEM-1:OFF_W], {OFF_W{1'b0}}}) << DDR_ADDR_SHIFT) : '0;
   assign ddr_wr_addr = (state_q == S_EVICT) ?
      (DDR_ADDR_WIDTH'({tag_q[line_q], line_q, {OFF_W{1'b0}}}) << DDR_ADDR_SHIFT) : '0;
   assign ddr_wr_data = ((state_q == S_EVICT) && (wr_beat_q < BEAT_W'(LINE_DEPTH))) ?
      mem_q[line_q][wr_beat_q[OFF_W-1:0]] : '0;

endmodule

// File: tb/tb_data_cache_ml.sv
// Directed bench for data_cache_ml: a behavioural DDR responder plus hand-computed expectations.
// DDR fill data for word address wa is always wa ^ 16'h3C3C.
module tb_data_cache_ml;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_rdy;
   logic [2:0]  cmd;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_col;
   logic [15:0] wdata_rbr, wdata_cbc;
   logic        resp_valid, resp_err;
   logic [15:0] rdata_rbr, rdata_cbc, miss_cnt;
   logic        ddr_rd_req, ddr_rd_valid, ddr_rd_done;
   logic [27:0] ddr_rd_addr, ddr_wr_addr;
   logic [15:0] ddr_rd_data, ddr_wr_data;
   logic        ddr_wr_req, ddr_wr_data_req, ddr_wr_done;

   data_cache_ml dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd(cmd),
      .cmd_addr(cmd_addr), .cmd_col(cmd_col), .wdata_rbr(wdata_rbr), .wdata_cbc(wdata_cbc),
      .resp_valid(resp_valid), .resp_err(resp_err), .rdata_rbr(rdata_rbr), .rdata_cbc(rdata_cbc),
      .miss_cnt(miss_cnt), .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr),
      .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data), .ddr_rd_done(ddr_rd_done),
      .ddr_wr_req(ddr_wr_req), .ddr_wr_addr(ddr_wr_addr), .ddr_wr_data_req(ddr_wr_data_req),
      .ddr_wr_data(ddr_wr_data), .ddr_wr_done(ddr_wr_done)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          lat, n_fill, n_wb;
   logic [27:0] fill_addr;
   logic [27:0] wb_addr [4];
   logic [15:0] wb_data [4][16];
   logic        r_err, ovl;
   logic [15:0] r_rbr, r_cbc;

   function automatic logic [15:0] fill_word(input logic [15:0] wa);
      return wa ^ 16'h3C3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one command, act as DDR until the response pulse, record what happened
   task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, input logic [7:0] col,
                          input logic [15:0] wr, input logic [15:0] wc);
      int   rd_cnt, wb_beat;
      logic prev_wr;
      n_fill = 0; n_wb = 0; lat = -1; ovl = 1'b0;
      rd_cnt = 0; wb_beat = 0; prev_wr = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd = c; cmd_addr = a; cmd_col = col; wdata_rbr = wr; wdata_cbc = wc;
      for (int n = 1; n <= 300 && lat < 0; n++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0; ddr_wr_data_req = 1'b0; ddr_wr_done = 1'b0;
         if (ddr_rd_req && ddr_wr_req) ovl = 1'b1;
         if (!ddr_rd_req) rd_cnt = 0;
         if (resp_valid) begin
            lat = n; r_err = resp_err; r_rbr = rdata_rbr; r_cbc = rdata_cbc;
         end else if (ddr_rd_req) begin
            if (rd_cnt == 0) begin n_fill++; fill_addr = ddr_rd_addr; end
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = fill_word(16'(fill_addr >> 3) + 16'(rd_cnt));
            ddr_rd_done  = (rd_cnt == 15);
            rd_cnt++;
         end else if (ddr_wr_req) begin
            if (!prev_wr) begin
               if (n_wb < 4) wb_addr[n_wb] = ddr_wr_addr;
               wb_beat = 0;
               n_wb++;
            end
            if (wb_beat < 16) begin
               ddr_wr_data_req = 1'b1;
               if (n_wb <= 4) wb_data[n_wb-1][wb_beat] = ddr_wr_data;
               wb_beat++;
            end else begin
               ddr_wr_done = 1'b1;
            end
         end
         prev_wr = ddr_wr_req;
      end
      chk("resp_seen", 32'(lat > 0), 32'd1);
      chk("no_req_overlap", 32'(ovl), 32'd0);
   endtask

   int beats, guard;

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd = '0; cmd_addr = '0; cmd_col = '0;
      wdata_rbr = '0; wdata_cbc = '0;
      ddr_rd_valid = 1'b0; ddr_rd_data = '0; ddr_rd_done = 1'b0;
      ddr_wr_data_req = 1'b0; ddr_wr_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      chk("rst_rd_req", 32'(ddr_rd_req), 32'd0);
      chk("rst_wr_req", 32'(ddr_wr_req), 32'd0);
      chk("rst_rdata_rbr", 32'(rdata_rbr), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // NOP: accepted, no response
      cmd_valid = 1'b1; cmd = 3'd0;
      @(negedge clk); cmd_valid = 1'b0;
      chk("nop_rdy", 32'(cmd_rdy), 32'd1);
      chk("nop_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("nop_no_resp2", 32'(resp_valid), 32'd0);

      // Cold row load
      run_cmd(3'd1, 16'h5003, 8'd0, 16'h0, 16'h0);
      chk("cold_nfill", 32'(n_fill), 32'd1);
      chk("cold_fill_addr", 32'(fill_addr), 32'h28000);
      chk("cold_rdata", 32'(r_rbr), 32'h6C3F);
      chk("cold_miss", 32'(miss_cnt), 32'd1);
      chk("cold_lat", 32'(lat), 32'd19);
      chk("cold_err", 32'(r_err), 32'd0);

      // Hit load
      run_cmd(3'd1, 16'h5007, 8'd0, 16'h0, 16'h0);
      chk("hit_lat", 32'(lat), 32'd2);
      chk("hit_nfill", 32'(n_fill), 32'd0);
      chk("hit_rdata", 32'(r_rbr), 32'h6C3B);
      chk("hit_miss", 32'(miss_cnt), 32'd1);

      // Hit store, then conflicting load forces write-back
      run_cmd(3'd2, 16'h5001, 8'd0, 16'hBEEF, 16'h0);
      chk("st_lat", 32'(lat), 32'd2);
      chk("st_nfill", 32'(n_fill), 32'd0);
      run_cmd(3'd1, 16'h5041, 8'd0, 16'h0, 16'h0);
      chk("wb_count", 32'(n_wb), 32'd1);
      chk("wb_addr", 32'(wb_addr[0]), 32'h28000);
      chk("wb_beat0", 32'(wb_data[0][0]), 32'h6C3C);
      chk("wb_beat1", 32'(wb_data[0][1]), 32'hBEEF);
      chk("wb_beat15", 32'(wb_data[0][15]), 32'h6C33);
      chk("wb_fill_addr", 32'(fill_addr), 32'h28200);
      chk("wb_rdata", 32'(r_rbr), 32'h6C7D);
      chk("wb_miss", 32'(miss_cnt), 32'd2);

      // Column store / load
      run_cmd(3'd4, 16'h5040, 8'd5, 16'h0, 16'hA5A5);
      chk("colst_lat", 32'(lat), 32'd2);
      run_cmd(3'd3, 16'h5040, 8'd5, 16'h0, 16'h0);
      chk("colld_lat", 32'(lat), 32'd2);
      chk("colld_data", 32'(r_cbc), 32'hA5A5);
      run_cmd(3'd1, 16'h5040, 8'd0, 16'h0, 16'h0);
      chk("col_word0", 32'(r_rbr), 32'h6C7C);
      run_cmd(3'd1, 16'h5041, 8'd0, 16'h0, 16'h0);
      chk("col_word1", 32'(r_rbr), 32'h6C5D);

      // Out-of-range column and reserved command
      run_cmd(3'd3, 16'h5040, 8'd16, 16'h0, 16'h0);
      chk("badcol_err", 32'(r_err), 32'd1);
      chk("badcol_lat", 32'(lat), 32'd2);
      chk("badcol_ddr", 32'(n_fill + n_wb), 32'd0);
      chk("badcol_miss", 32'(miss_cnt), 32'd2);
      chk("badcol_cbc_held", 32'(r_cbc), 32'hA5A5);
      run_cmd(3'd7, 16'h1234, 8'd0, 16'h0, 16'h0);
      chk("rsvd_err", 32'(r_err), 32'd1);
      chk("rsvd_miss", 32'(miss_cnt), 32'd2);
      run_cmd(3'd1, 16'h5041, 8'd0, 16'h0, 16'h0);
      chk("badcol_unchanged", 32'(r_rbr), 32'h6C5D);
      chk("badcol_unchanged_err", 32'(r_err), 32'd0);

      // Invalidate drops dirty line 0 without write-back
      run_cmd(3'd6, 16'h0, 8'd0, 16'h0, 16'h0);
      chk("inval_lat", 32'(lat), 32'd2);
      chk("inval_nwb", 32'(n_wb), 32'd0);
      run_cmd(3'd1, 16'h5040, 8'd0, 16'h0, 16'h0);
      chk("inval_refill", 32'(n_fill), 32'd1);
      chk("inval_nowb", 32'(n_wb), 32'd0);
      chk("inval_rdata", 32'(r_rbr), 32'h6C7C);
      chk("inval_miss", 32'(miss_cnt), 32'd3);

      // Dirty lines 1 and 3, then flush
      run_cmd(3'd2, 16'h6010, 8'd0, 16'h1111, 16'h0);
      run_cmd(3'd2, 16'h7035, 8'd0, 16'h3333, 16'h0);
      chk("pre_flush_miss", 32'(miss_cnt), 32'd5);
      run_cmd(3'd5, 16'h0, 8'd0, 16'h0, 16'h0);
      chk("flush_nwb", 32'(n_wb), 32'd2);
      chk("flush_nfill", 32'(n_fill), 32'd0);
      chk("flush_addr0", 32'(wb_addr[0]), 32'h30080);
      chk("flush_addr1", 32'(wb_addr[1]), 32'h38180);
      chk("flush_l1_b0", 32'(wb_data[0][0]), 32'h1111);
      chk("flush_l1_b1", 32'(wb_data[0][1]), 32'h5C2D);
      chk("flush_l3_b0", 32'(wb_data[1][0]), 32'h4C0C);
      chk("flush_l3_b5", 32'(wb_data[1][5]), 32'h3333);
      run_cmd(3'd5, 16'h0, 8'd0, 16'h0, 16'h0);
      chk("flush2_lat", 32'(lat), 32'd5);
      chk("flush2_nwb", 32'(n_wb), 32'd0);

      // Reset during fill beat 7
      @(negedge clk);
      cmd_valid = 1'b1; cmd = 3'd1; cmd_addr = 16'h9020;
      beats = 0; guard = 0;
      while (beats < 8 && guard < 100) begin
         @(negedge clk);
         cmd_valid = 1'b0; guard++;
         ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
         if (ddr_rd_req) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = fill_word(16'h9020 + 16'(beats));
            beats++;
         end
      end
      chk("rstfill_req_before", 32'(ddr_rd_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstfill_req_dropped", 32'(ddr_rd_req), 32'd0);
      chk("rstfill_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("rstfill_miss_cnt", 32'(miss_cnt), 32'd0);
      ddr_rd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_cmd(3'd1, 16'h9020, 8'd0, 16'h0, 16'h0);
      chk("post_rst_nfill", 32'(n_fill), 32'd1);
      chk("post_rst_fill_addr", 32'(fill_addr), 32'h48100);
      chk("post_rst_miss", 32'(miss_cnt), 32'd1);
      chk("post_rst_rdata", 32'(r_rbr), 32'hAC1C);
      chk("post_rst_lat", 32'(lat), 32'd19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
